regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined core; successor to the single-write, two-read file.
- Configurable width, depth, read-port count and write-port count.
- Register 0 is hardwired to zero.
- Integrated per-register pending scoreboard, set at issue and cleared at writeback, lets decode detect RAW hazards without an external table.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of architectural registers; power of two, at least 4.
- NR, 2, number of read ports, 1..4.
- NW, 1, number of write (writeback) ports, 1..2.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clock  in  1  rising-edge clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- rd_addr  in  NR x AW  read addresses.
- rd_data  out  NR x DW  read data, combinational.
- rd_busy  out  NR  pending bit of addressed register.
- wr_en  in  NW  writeback enables.
- wr_addr  in  NW x AW  writeback addresses.
- wr_data  in  NW x DW  writeback data.
- iss_en  in  1  issue: mark destination pending.
- iss_addr  in  AW  issued destination register.
- flush  in  1  clear all pending bits (pipeline flush).
- any_busy  out  1  OR of all pending bits, registered state.

Behaviour:
- Storage: DEPTH x DW array plus DEPTH pending bits. Entry 0 is never written and its pending bit is never set. rd_data for address 0 is always 0 and rd_busy is always 0.
- Reset (synchronous, active-high): all entries are cleared to 0 and all pending bits are cleared. After the reset edge, every rd_data is 0, every rd_busy is 0 and any_busy is 0. Reset overrides wr_en, iss_en and flush in the same cycle. Reset asserted mid-operation discards in-flight issues.
- Write: at posedge, when wr_en[i] is set and wr_addr[i] is not 0, the entry takes wr_data[i].
- Write collision: when two ports target the same address, the higher-index port wins.
- Pending update order at posedge, highest priority first: reset, then flush, then issue-set, then writeback-clear.
  - Writeback clears the pending bit of each enabled, nonzero wr_addr.
  - iss_en sets the pending bit of iss_addr when iss_addr is not 0.
  - If iss_addr equals a same-cycle writeback address, the bit ends set, because the new producer wins.
  - flush clears every pending bit, including any same-cycle issue.
  - flush does not touch data.
- Writeback to a register that is not pending is legal: data is written and the bit stays 0.
- Issue to a register that is already pending is legal: the bit stays 1 (no counting).
- Read latency: combinational from registered state (0 cycles). Without bypass, a write becomes visible the cycle after the edge.
- any_busy is the OR-reduction of the registered pending vector.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd_data[j] returns wr_data of the highest-index port with wr_en set and wr_addr equal to a nonzero rd_addr[j] in the same cycle, otherwise the stored value.
  - rd_busy[j] is forced to 0 when such a matching writeback exists and iss_en does not target the same register this cycle.
- Undefined: reads return stored state only; rd_busy reflects the registered pending bit only. The posedge update rules are identical in both builds.

Decomposition:
- Package regfile_pkg holds:
  - constants REG_ZERO = 0, default DW and DEPTH;
  - typedef reg_addr_t (logic [AW-1:0]);
  - typedef reg_data_t (logic [DW-1:0]);
  - a function resolving multi-port write priority, shared by the data array and the bypass path.
- Sub-module regfile_scoreboard (DEPTH pending bits with set, clear and flush priority, plus any_busy). The top-level module instantiates it alongside the data array.

Test Plan:
- Reset then read: write 0xDEADBEEF to x5, pulse reset for 1 cycle, read x5 -> 0; rd_busy 0; any_busy 0.
- x0 protection: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF; iss_addr=0 with iss_en=1 -> rd_data[x0]=0, rd_busy=0, any_busy=0.
- Scoreboard lifecycle: issue x7 at cycle 1 -> rd_busy(x7)=1 at cycle 2. Writeback x7=0x12345678 at cycle 4 -> cycle 5 rd_data=0x12345678, rd_busy=0.
- Simultaneous issue and writeback on x9 -> bit remains 1 next cycle and data is updated. Adding flush the same cycle -> bit 0.
- NW=2 collision: port0 writes x3=0x11, port1 writes x3=0x22 in the same cycle -> next cycle x3=0x22.
- With REGFILE_BYPASS_EN: read x4 while writing x4=0xA5A5A5A5 -> same-cycle rd_data=0xA5A5A5A5 and rd_busy=0. Without the macro -> old value, with rd_busy per registered bit.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types, constants and the multi-port write-priority helper for regfile_mp.
package regfile_pkg;

    localparam int REG_ZERO      = 0;
    localparam int DEFAULT_DW    = 32;
    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    // Hit vectors are sized for the widest supported writer set.
    localparam int MAX_WP   = 4;
    localparam int WP_IDX_W = 2;

    typedef logic [DEFAULT_AW-1:0] reg_addr_t;
    typedef logic [DEFAULT_DW-1:0] reg_data_t;

    // Returns {valid, index} of the highest-index set bit; later ports overwrite earlier ones.
    function automatic logic [WP_IDX_W:0] pick_writer(input logic [MAX_WP-1:0] hit);
        logic [WP_IDX_W:0] sel;
        sel = '0;
        for (int p = 0; p < MAX_WP; p++) begin
            if (hit[p]) begin
                sel = {1'b1, WP_IDX_W'(p)};
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: writeback clears, issue sets, flush and reset clear all.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int NW    = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NW-1:0]          wr_en,
    input  logic [NW-1:0][AW-1:0]  wr_addr,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic [DEPTH-1:0]       pend,
    output logic                   any_busy
);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic             any_busy_q, any_busy_d;

    // Lowest priority applied first so later statements override it.
    always_comb begin
        pend_d = pend_q;
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p] && (wr_addr[p] != AW'(REG_ZERO))) begin
                pend_d[wr_addr[p]] = 1'b0;
            end
        end
        if (iss_en && (iss_addr != AW'(REG_ZERO))) begin
            pend_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
        pend_d[REG_ZERO] = 1'b0;
        any_busy_d = |pend_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            any_busy_q <= any_busy_d;
        end
    end

    assign pend     = pend_q;
    assign any_busy = any_busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and an integrated pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and busy-clear to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int NR    = 2,
    parameter int NW    = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NR-1:0][AW-1:0]  rd_addr,
    output logic [NR-1:0][DW-1:0]  rd_data,
    output logic [NR-1:0]          rd_busy,
    input  logic [NW-1:0]          wr_en,
    input  logic [NW-1:0][AW-1:0]  wr_addr,
    input  logic [NW-1:0][DW-1:0]  wr_data,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic                   any_busy
);

    logic [DEPTH-1:0][DW-1:0] entries;
    logic [DEPTH-1:0]         pend;

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NW    (NW)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .pend     (pend),
        .any_busy (any_busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == REG_ZERO) begin : g_zero
                assign entries[gi] = '0;
            end else begin : g_reg
                logic [DW-1:0]       entry_q, entry_d;
                logic [MAX_WP-1:0]   hit;
                logic [WP_IDX_W:0]   sel;

                always_comb begin
                    hit = '0;
                    for (int p = 0; p < NW; p++) begin
                        hit[p] = wr_en[p] && (wr_addr[p] == AW'(gi));
                    end
                    sel     = pick_writer(hit);
                    entry_d = entry_q;
                    for (int p = 0; p < NW; p++) begin
                        if (sel[WP_IDX_W] && (sel[WP_IDX_W-1:0] == WP_IDX_W'(p))) begin
                            entry_d = wr_data[p];
                        end
                    end
                end

                always_ff @(posedge clock) begin
                    if (reset) begin
                        entry_q <= '0;
                    end else begin
                        entry_q <= entry_d;
                    end
                end

                assign entries[gi] = entry_q;
            end
        end

        for (gi = 0; gi < NR; gi++) begin : g_rd
            logic [DW-1:0] rd_data_j;
            logic          rd_busy_j;
`ifdef REGFILE_BYPASS_EN
            logic [MAX_WP-1:0] hit;
            logic [WP_IDX_W:0] sel;
`endif

            always_comb begin
                // Entry 0 and its pending bit are constant zero, so address 0 needs no special case.
                rd_data_j = entries[rd_addr[gi]];
                rd_busy_j = pend[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                hit = '0;
                for (int p = 0; p < NW; p++) begin
                    hit[p] = wr_en[p] && (rd_addr[gi] != AW'(REG_ZERO))
                             && (wr_addr[p] == rd_addr[gi]);
                end
                sel = pick_writer(hit);
                if (sel[WP_IDX_W]) begin
                    for (int p = 0; p < NW; p++) begin
                        if (sel[WP_IDX_W-1:0] == WP_IDX_W'(p)) begin
                            rd_data_j = wr_data[p];
                        end
                    end
                    // A same-cycle re-issue means a newer producer is still outstanding.
                    if (!(iss_en && (iss_addr == rd_addr[gi]))) begin
                        rd_busy_j = 1'b0;
                    end
                end
`endif
            end

            assign rd_data[gi] = rd_data_j;
            assign rd_busy[gi] = rd_busy_j;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (NR=2, NW=2); expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int AW    = $clog2(DEPTH);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   clock;
    logic                   reset;
    logic [NR-1:0][AW-1:0]  rd_addr;
    logic [NR-1:0][DW-1:0]  rd_data;
    logic [NR-1:0]          rd_busy;
    logic [NW-1:0]          wr_en;
    logic [NW-1:0][AW-1:0]  wr_addr;
    logic [NW-1:0][DW-1:0]  wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic                   flush;
    logic                   any_busy;

    int n_cmp;
    int n_mis;

    regfile_mp #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .NR    (NR),
        .NW    (NW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .any_busy (any_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
        flush  = 1'b0;
        reset  = 1'b0;
        #1;
    endtask

    task automatic wb(input int port, input int addr, input reg_data_t data);
        wr_en[port]   = 1'b1;
        wr_addr[port] = AW'(addr);
        wr_data[port] = data;
    endtask

    task automatic issue(input int addr);
        iss_en   = 1'b1;
        iss_addr = AW'(addr);
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        reset    = 1'b1;
        tick();
        idle();

        // Reset then read: x5 written and issued, then wiped by reset.
        rd_addr[0] = AW'(5);
        wb(0, 5, 32'hDEADBEEF);
        issue(5);
        tick();
        idle();
        check("x5_written", rd_data[0], 32'hDEADBEEF);
        check("x5_busy_set", 32'(rd_busy[0]), 32'd1);
        check("any_busy_set", 32'(any_busy), 32'd1);
        reset = 1'b1;
        tick();
        idle();
        check("rst_x5_data", rd_data[0], 32'h0);
        check("rst_x5_busy", 32'(rd_busy[0]), 32'd0);
        check("rst_any_busy", 32'(any_busy), 32'd0);

        // x0 protection, including the same-cycle read path.
        rd_addr[0] = AW'(0);
        wb(0, 0, 32'hFFFFFFFF);
        issue(0);
        #1;
        check("x0_same_cycle_data", rd_data[0], 32'h0);
        check("x0_same_cycle_busy", 32'(rd_busy[0]), 32'd0);
        tick();
        idle();
        check("x0_data", rd_data[0], 32'h0);
        check("x0_busy", 32'(rd_busy[0]), 32'd0);
        check("x0_any_busy", 32'(any_busy), 32'd0);

        // Scoreboard lifecycle on x7.
        rd_addr[0] = AW'(7);
        issue(7);
        tick();
        idle();
        check("x7_busy_after_issue", 32'(rd_busy[0]), 32'd1);
        check("x7_any_busy", 32'(any_busy), 32'd1);
        tick();
        tick();
        check("x7_still_busy", 32'(rd_busy[0]), 32'd1);
        wb(0, 7, 32'h12345678);
        #1;
        check("x7_wb_cycle_data", rd_data[0], BYP ? 32'h12345678 : 32'h0);
        check("x7_wb_cycle_busy", 32'(rd_busy[0]), BYP ? 32'd0 : 32'd1);
        tick();
        idle();
        check("x7_data", rd_data[0], 32'h12345678);
        check("x7_busy_clear", 32'(rd_busy[0]), 32'd0);
        check("x7_any_busy_clear", 32'(any_busy), 32'd0);

        // Issue and writeback same cycle: new producer wins.
        rd_addr[0] = AW'(9);
        wb(1, 9, 32'h00000099);
        issue(9);
        #1;
        check("x9_same_cycle_busy", 32'(rd_busy[0]), 32'd0);
        tick();
        idle();
        check("x9_data", rd_data[0], 32'h00000099);
        check("x9_busy_kept", 32'(rd_busy[0]), 32'd1);
        // Same again plus flush: flush clears the bit but data still lands.
        wb(0, 9, 32'h0000009A);
        issue(9);
        flush = 1'b1;
        #1;
        check("x9_reissue_busy", 32'(rd_busy[0]), 32'd1);
        tick();
        idle();
        check("x9_flush_data", rd_data[0], 32'h0000009A);
        check("x9_flush_busy", 32'(rd_busy[0]), 32'd0);
        check("x9_flush_any_busy", 32'(any_busy), 32'd0);

        // Two-port collision on x3, observed on read port 1.
        rd_addr[1] = AW'(3);
        wb(0, 3, 32'h00000011);
        wb(1, 3, 32'h00000022);
        #1;
        check("x3_collide_cycle", rd_data[1], BYP ? 32'h00000022 : 32'h0);
        tick();
        idle();
        check("x3_collide", rd_data[1], 32'h00000022);

        // Same-cycle read of x4 while it is pending and being written.
        rd_addr[0] = AW'(4);
        wb(0, 4, 32'h00000044);
        issue(4);
        tick();
        idle();
        check("x4_old", rd_data[0], 32'h00000044);
        wb(1, 4, 32'hA5A5A5A5);
        #1;
        check("x4_bypass_data", rd_data[0], BYP ? 32'hA5A5A5A5 : 32'h00000044);
        check("x4_bypass_busy", 32'(rd_busy[0]), BYP ? 32'd0 : 32'd1);
        check("x3_port1_unaffected", rd_data[1], 32'h00000022);
        tick();
        idle();
        check("x4_new", rd_data[0], 32'hA5A5A5A5);
        check("x4_busy_clear", 32'(rd_busy[0]), 32'd0);

        // Reset overrides same-cycle issue and write.
        rd_addr[0] = AW'(11);
        rd_addr[1] = AW'(4);
        issue(11);
        wb(0, 11, 32'h0BADF00D);
        reset = 1'b1;
        tick();
        idle();
        check("rst_drops_issue", 32'(rd_busy[0]), 32'd0);
        check("rst_drops_write", rd_data[0], 32'h0);
        check("rst_clears_x4", rd_data[1], 32'h0);
        check("rst_any_busy2", 32'(any_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
